id_stage_pipe: RTL and testbench

- Parametrised decode stage for the RV32I/RV64I pipeline: integrated decoder, immediate generator, register file and ID/EX pipeline register, with a valid/ready handshake on both sides.
- Adds three things the earlier decode block lacks: write-through bypass from write-back, load-use stall detection, and flush.
- Sits between the IF stage (upstream) and the EX stage (downstream).

---
 rtl/id_stage_pipe.sv | 252 +++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// Decode stage: RV32I/RV64I decoder, immediate generator, register file with
// write-back bypass, load-use stall detection, flush and the ID/EX register.
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rs1,
    output logic [AW-1:0]   ex_rs2,
    output logic [AW-1:0]   ex_rd,
    output logic [2:0]      ex_mem_read,
    output logic [1:0]      ex_mem_write,
    output logic [1:0]      ex_wb_sel,
    output logic            ex_alu_a_src,
    output logic            ex_alu_b_src,
    output logic [5:0]      ex_alu_code,
    output logic [5:0]      ex_branch_flag,
    output logic [1:0]      ex_jump,
    output logic            ex_wb_en,
    output logic            ex_illegal
);
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // ready never depends on the valid of the same interface.

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [2:0]      mem_read;
        logic [1:0]      mem_write;
        logic [1:0]      wb_sel;
        logic            alu_a_src;
        logic            alu_b_src;
        logic [5:0]      alu_code;
        logic [5:0]      branch_flag;
        logic [1:0]      jump;
        logic            wb_en;
        logic            illegal;
    } idex_t;

    logic [XLEN-1:0] regs [NREG];
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [AW-1:0]   rs1_a, rs2_a, rd_a;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            rs1_used, rs2_used, bad, hz, adv;
    idex_t           d, q;

    assign opcode = if_instr[6:0];
    assign f3     = if_instr[14:12];
    assign rs1_a  = if_instr[15 +: AW];
    assign rs2_a  = if_instr[20 +: AW];
    assign rd_a   = if_instr[7 +: AW];

    assign imm_i = XLEN'($signed(if_instr[31:20]));
    assign imm_s = XLEN'($signed({if_instr[31:25], if_instr[11:7]}));
    assign imm_b = XLEN'($signed({if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({if_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // x0 reads as zero; same-cycle write-back is forwarded when BYPASS is set.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_a != '0)
            rs1_data = (BYPASS != 0 && wb_en && wb_addr == rs1_a) ? wb_data : regs[rs1_a];
        if (rs2_a != '0)
            rs2_data = (BYPASS != 0 && wb_en && wb_addr == rs2_a) ? wb_data : regs[rs2_a];
    end

    always_comb begin
        d          = '0;
        bad        = 1'b0;
        rs1_used   = 1'b1;
        rs2_used   = 1'b0;
        d.valid    = if_valid;
        d.pc       = if_pc;
        d.rs1      = rs1_a;
        d.rs2      = rs2_a;
        d.rd       = rd_a;
        d.rs1_data = rs1_data;
        d.rs2_data = rs2_data;
        case (opcode)
            OP_OP: begin
                rs2_used   = 1'b1;
                d.wb_en    = 1'b1;
                d.alu_code = {2'b00, if_instr[30], f3};
            end
            OP_IMM: begin
                d.wb_en     = 1'b1;
                d.alu_b_src = 1'b1;
                d.imm       = imm_i;
                d.alu_code  = {2'b00, (f3 == 3'b101) & if_instr[30], f3};
            end
            OP_LOAD: begin
                d.wb_en     = 1'b1;
                d.alu_b_src = 1'b1;
                d.imm       = imm_i;
                d.wb_sel    = 2'b01;
                case (f3)
                    3'b000:  d.mem_read = 3'b001;
                    3'b001:  d.mem_read = 3'b010;
                    3'b010:  d.mem_read = 3'b011;
                    3'b100:  d.mem_read = 3'b100;
                    3'b101:  d.mem_read = 3'b101;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                rs2_used    = 1'b1;
                d.alu_b_src = 1'b1;
                d.imm       = imm_s;
                case (f3)
                    3'b000:  d.mem_write = 2'b01;
                    3'b001:  d.mem_write = 2'b10;
                    3'b010:  d.mem_write = 2'b11;
                    default: bad = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                rs2_used   = 1'b1;
                d.imm      = imm_b;
                d.alu_code = 6'b001000;
                case (f3)
                    3'b000:  d.branch_flag = 6'b000001;
                    3'b001:  d.branch_flag = 6'b000010;
                    3'b100:  d.branch_flag = 6'b000100;
                    3'b101:  d.branch_flag = 6'b001000;
                    3'b110:  d.branch_flag = 6'b010000;
                    3'b111:  d.branch_flag = 6'b100000;
                    default: bad = 1'b1;
                endcase
            end
            OP_LUI: begin
                rs1_used    = 1'b0;
                d.wb_en     = 1'b1;
                d.alu_b_src = 1'b1;
                d.imm       = imm_u;
                d.alu_code  = 6'b100000;
            end
            OP_AUIPC: begin
                rs1_used    = 1'b0;
                d.wb_en     = 1'b1;
                d.alu_a_src = 1'b1;
                d.alu_b_src = 1'b1;
                d.imm       = imm_u;
            end
            OP_JAL: begin
                rs1_used    = 1'b0;
                d.wb_en     = 1'b1;
                d.alu_a_src = 1'b1;
                d.alu_b_src = 1'b1;
                d.imm       = imm_j;
                d.wb_sel    = 2'b10;
                d.jump      = 2'b01;
            end
            OP_JALR: begin
                d.wb_en     = 1'b1;
                d.alu_b_src = 1'b1;
                d.imm       = imm_i;
                d.wb_sel    = 2'b10;
                d.jump      = 2'b10;
            end
            default: bad = 1'b1;
        endcase
        // RV32E: any used register field naming x16..x31 is undecodable.
        if (NREG < 32 && ((rs1_used && if_instr[19]) || (rs2_used && if_instr[24]) ||
                          (d.wb_en && if_instr[11])))
            bad = 1'b1;
        if (bad) begin
            d.illegal     = 1'b1;
            d.wb_en       = 1'b0;
            d.mem_read    = '0;
            d.mem_write   = '0;
            d.branch_flag = '0;
            d.jump        = '0;
        end
    end

    assign hz = q.valid && (q.mem_read != 3'b000) && (q.rd != '0) &&
                ((rs1_used && q.rd == rs1_a) || (rs2_used && q.rd == rs2_a));
    assign adv      = !q.valid || ex_ready;
    assign if_ready = adv && !hz && !rst;

    // Flush kills the slot even while EX is stalled; a hazard inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            q <= '0;
        else if (flush)     q <= '0;
        else if (adv && hz) q <= '0;
        else if (adv)       q <= d;
    end

    assign ex_valid       = q.valid;
    assign ex_pc          = q.pc;
    assign ex_rs1_data    = q.rs1_data;
    assign ex_rs2_data    = q.rs2_data;
    assign ex_imm         = q.imm;
    assign ex_rs1         = q.rs1;
    assign ex_rs2         = q.rs2;
    assign ex_rd          = q.rd;
    assign ex_mem_read    = q.mem_read;
    assign ex_mem_write   = q.mem_write;
    assign ex_wb_sel      = q.wb_sel;
    assign ex_alu_a_src   = q.alu_a_src;
    assign ex_alu_b_src   = q.alu_b_src;
    assign ex_alu_code    = q.alu_code;
    assign ex_branch_flag = q.branch_flag;
    assign ex_jump        = q.jump;
    assign ex_wb_en       = q.wb_en;
    assign ex_illegal     = q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: a BYPASS=1 and a BYPASS=0 instance on shared inputs,
// an instruction-level model checked every cycle, and directed literal checks.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = 32'h100;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;

    logic        if_ready, ex_valid, ex_alu_a_src, ex_alu_b_src, ex_wb_en, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_mem_read;
    logic [1:0]  ex_mem_write, ex_wb_sel, ex_jump;
    logic [5:0]  ex_alu_code, ex_branch_flag;

    logic        nb_if_ready, nb_ex_valid, nb_ex_alu_a_src, nb_ex_alu_b_src, nb_ex_wb_en, nb_ex_illegal;
    logic [31:0] nb_ex_pc, nb_ex_rs1_data, nb_ex_rs2_data, nb_ex_imm;
    logic [4:0]  nb_ex_rs1, nb_ex_rs2, nb_ex_rd;
    logic [2:0]  nb_ex_mem_read;
    logic [1:0]  nb_ex_mem_write, nb_ex_wb_sel, nb_ex_jump;
    logic [5:0]  nb_ex_alu_code, nb_ex_branch_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_wb_sel(ex_wb_sel), .ex_alu_a_src(ex_alu_a_src), .ex_alu_b_src(ex_alu_b_src),
        .ex_alu_code(ex_alu_code), .ex_branch_flag(ex_branch_flag), .ex_jump(ex_jump),
        .ex_wb_en(ex_wb_en), .ex_illegal(ex_illegal)
    );

    id_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(nb_if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .ex_ready(ex_ready), .ex_valid(nb_ex_valid), .ex_pc(nb_ex_pc),
        .ex_rs1_data(nb_ex_rs1_data), .ex_rs2_data(nb_ex_rs2_data), .ex_imm(nb_ex_imm),
        .ex_rs1(nb_ex_rs1), .ex_rs2(nb_ex_rs2), .ex_rd(nb_ex_rd),
        .ex_mem_read(nb_ex_mem_read), .ex_mem_write(nb_ex_mem_write),
        .ex_wb_sel(nb_ex_wb_sel), .ex_alu_a_src(nb_ex_alu_a_src),
        .ex_alu_b_src(nb_ex_alu_b_src), .ex_alu_code(nb_ex_alu_code),
        .ex_branch_flag(nb_ex_branch_flag), .ex_jump(nb_ex_jump), .ex_wb_en(nb_ex_wb_en),
        .ex_illegal(nb_ex_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, rs1_nb, rs2_nb, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  mem_read;
        logic [1:0]  mem_write, wb_sel, jump;
        logic        a_src, b_src, wb_en, illegal;
        logic [5:0]  alu_code, branch_flag;
    } exp_t;

    exp_t        m = '0;
    logic [31:0] m_rf [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && wb_en && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    // Architectural meaning of one instruction, from the ISA field layout.
    function automatic exp_t expect_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   f3;
        f3 = int'(ins[14:12]);
        e = '0;
        e.valid = 1'b1; e.pc = pc;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.rs1_data = rd_reg(e.rs1, 1'b1); e.rs2_data = rd_reg(e.rs2, 1'b1);
        e.rs1_nb = rd_reg(e.rs1, 1'b0); e.rs2_nb = rd_reg(e.rs2, 1'b0);
        case (ins[6:0])
            7'h33: begin e.wb_en = 1; e.alu_code = 6'(int'(ins[30]) * 8 + f3); end
            7'h13: begin
                e.wb_en = 1; e.b_src = 1; e.imm = 32'(sx(int'(ins[31:20]), 12));
                e.alu_code = 6'(((f3 == 5) ? int'(ins[30]) * 8 : 0) + f3);
            end
            7'h03: begin
                e.wb_en = 1; e.b_src = 1; e.wb_sel = 1; e.imm = 32'(sx(int'(ins[31:20]), 12));
                e.mem_read = (f3 == 0) ? 3'd1 : (f3 == 1) ? 3'd2 : (f3 == 2) ? 3'd3 : 3'(f3);
            end
            7'h23: begin
                e.b_src = 1; e.mem_write = 2'(f3 + 1);
                e.imm = 32'(sx(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12));
            end
            7'h63: begin
                e.alu_code = 6'd8;
                e.imm = 32'(sx(int'(ins[31]) * 4096 + int'(ins[7]) * 2048 +
                               int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2, 13));
                e.branch_flag = 6'(1 << ((f3 < 2) ? f3 : f3 - 2));
            end
            7'h37: begin e.wb_en = 1; e.b_src = 1; e.alu_code = 6'd32; e.imm = {ins[31:12], 12'h0}; end
            7'h17: begin e.wb_en = 1; e.a_src = 1; e.b_src = 1; e.imm = {ins[31:12], 12'h0}; end
            7'h6f: begin
                e.wb_en = 1; e.a_src = 1; e.b_src = 1; e.wb_sel = 2; e.jump = 1;
                e.imm = 32'(sx(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 +
                               int'(ins[20]) * 2048 + int'(ins[30:21]) * 2, 21));
            end
            7'h67: begin
                e.wb_en = 1; e.b_src = 1; e.wb_sel = 2; e.jump = 2;
                e.imm = 32'(sx(int'(ins[31:20]), 12));
            end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    function automatic bit model_hz();
        logic [6:0] op;
        bit u1, u2;
        op = if_instr[6:0];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return m.valid && m.mem_read != 0 && m.rd != 0 &&
               ((u1 && m.rd == if_instr[19:15]) || (u2 && m.rd == if_instr[24:20]));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m = '0;
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
        end else begin
            if (flush) m = '0;
            else if (!m.valid || ex_ready) begin
                if (model_hz()) m = '0;
                else if (if_valid) m = expect_decode(if_instr, if_pc);
                else m.valid = 1'b0;
            end
            if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
        end
    end

    always @(negedge clk) begin
        chk("ex_valid", ex_valid, m.valid);
        chk("if_ready", if_ready, !rst && (!m.valid || ex_ready) && !model_hz());
        chk("nb_ex_valid", nb_ex_valid, m.valid);
        if (m.valid) begin
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_rs1_data", ex_rs1_data, m.rs1_data);
            chk("ex_rs2_data", ex_rs2_data, m.rs2_data);
            chk("nb_rs1_data", nb_ex_rs1_data, m.rs1_nb);
            chk("nb_rs2_data", nb_ex_rs2_data, m.rs2_nb);
            chk("ex_imm", ex_imm, m.imm);
            chk("ex_rs_rd", {ex_rs1, ex_rs2, ex_rd}, {m.rs1, m.rs2, m.rd});
            chk("ex_mem", {ex_mem_read, ex_mem_write}, {m.mem_read, m.mem_write});
            chk("ex_wb_sel", ex_wb_sel, m.wb_sel);
            chk("ex_srcs", {ex_alu_a_src, ex_alu_b_src}, {m.a_src, m.b_src});
            chk("ex_alu_code", ex_alu_code, m.alu_code);
            chk("ex_branch_flag", ex_branch_flag, m.branch_flag);
            chk("ex_jump", ex_jump, m.jump);
            chk("ex_wb_en", ex_wb_en, m.wb_en);
            chk("ex_illegal", ex_illegal, m.illegal);
        end
    end

    task automatic send(input logic [31:0] ins);
        if_instr = ins;
        if_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if_ready) begin
                @(posedge clk); #2;
                if_valid = 1'b0;
                if_pc = if_pc + 4;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL send_timeout: instr %0h not accepted within 20 cycles", ins);
        if_valid = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        wb_en = 1'b1; wb_addr = a; wb_data = v;
        @(posedge clk); #2;
        wb_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_ex_imm", ex_imm, 0);
        rst = 1'b0;

        send(32'h00500093);  // addi x1,x0,5
        chk("addi_valid", ex_valid, 1);
        chk("addi_imm", ex_imm, 5);
        chk("addi_alu", ex_alu_code, 0);
        chk("addi_bsrc", ex_alu_b_src, 1);
        chk("addi_wb_en", ex_wb_en, 1);
        chk("addi_rd", ex_rd, 1);

        wr(5'd1, 32'h0000_1000);
        wr(5'd2, 32'h0000_0022);
        wr(5'd3, 32'h1111_1111);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
        send(32'h00018233);  // add x4,x3,x0 with same-cycle write of x3
        wb_en = 1'b0;
        chk("bypass_rs1", ex_rs1_data, 32'hDEAD_BEEF);
        chk("nobypass_rs1", nb_ex_rs1_data, 32'h1111_1111);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        send(32'h00018233);
        wb_en = 1'b0;
        chk("x0_read", ex_rs2_data, 0);
        chk("x3_committed", nb_ex_rs1_data, 32'hDEAD_BEEF);

        send(32'h0000A283);  // lw x5,0(x1)
        chk("lw_mem_read", ex_mem_read, 3'b011);
        chk("lw_wb_sel", ex_wb_sel, 2'b01);
        if_instr = 32'h00228333; if_valid = 1'b1;  // add x6,x5,x2
        @(negedge clk); chk("lu_ready_low", if_ready, 0);
        @(posedge clk); #2;
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_ctrl", {ex_mem_read, ex_wb_en, ex_alu_b_src}, 0);
        @(negedge clk); chk("lu_ready_high", if_ready, 1);
        @(posedge clk); #2;
        if_valid = 1'b0; if_pc = if_pc + 4;
        chk("lu_issue_valid", ex_valid, 1);
        chk("lu_issue_rd", ex_rd, 6);

        send(32'h0000A003);  // lw x0,0(x1)
        if_instr = 32'h00200333; if_valid = 1'b1;  // add x6,x0,x2
        @(negedge clk); chk("lu_x0_no_stall", if_ready, 1);
        @(posedge clk); #2;
        if_valid = 1'b0; if_pc = if_pc + 4;

        send(32'h4030D413);  // srai x8,x1,3
        chk("srai_alu", ex_alu_code, 6'b001101);
        send(32'h0040A423);  // sw x4,8(x1)
        chk("sw_imm", ex_imm, 8);
        send(32'hFE208EE3);  // beq x1,x2,-4
        chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
        chk("beq_flag", ex_branch_flag, 6'b000001);
        chk("beq_alu", ex_alu_code, 6'b001000);
        send(32'h123454B7);  // lui x9,0x12345
        chk("lui_imm", ex_imm, 32'h1234_5000);
        chk("lui_alu", ex_alu_code, 6'b100000);
        send(32'h010000EF);  // jal x1,16
        chk("jal_imm", ex_imm, 16);
        chk("jal_jump", {ex_jump, ex_wb_sel}, {2'b01, 2'b10});
        send(32'h00008067);  // jalr x0,0(x1)
        send(32'h00001517);  // auipc x10,1
        chk("auipc_asrc", ex_alu_a_src, 1);

        send(32'h404083B3);  // sub x7,x1,x4
        ex_ready = 1'b0;
        if_instr = 32'h00500093; if_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_if_ready", if_ready, 0);
            chk("stall_rd", {ex_valid, ex_rd}, {1'b1, 5'd7});
        end
        @(posedge clk); #2;
        ex_ready = 1'b1;
        @(posedge clk); #2;
        if_valid = 1'b0; if_pc = if_pc + 4;
        chk("release_rd", {ex_valid, ex_rd}, {1'b1, 5'd1});

        send(32'h404083B3);
        ex_ready = 1'b0; flush = 1'b1;
        if_instr = 32'h00500093; if_valid = 1'b1;
        @(negedge clk); chk("flush_if_ready", if_ready, 0);
        @(posedge clk); #2;
        flush = 1'b0; if_valid = 1'b0;
        chk("flush_kill", ex_valid, 0);
        @(posedge clk); #2;
        chk("flush_no_reissue", ex_valid, 0);
        ex_ready = 1'b1;

        send(32'h0000007F);
        chk("illegal_flag", {ex_valid, ex_illegal, ex_wb_en}, 3'b110);

        send(32'h00500093);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", ex_valid, 0);
        chk("async_rst_fields", {ex_imm, ex_rd, ex_wb_en, ex_alu_b_src}, 0);
        chk("async_rst_ready", if_ready, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        send(32'h00018233);
        chk("rf_cleared", ex_rs1_data, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        checks++; errors++;
        $display("FAIL watchdog: bench did not complete in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
